// File: rtl/vgg_pkg.sv
// Shared VGG16 datapath types: activation width, signed activation type and
// the signed max used by every pooling stage.
package vgg_pkg;

   localparam int DATA_SIZE = 8;

   typedef logic signed [DATA_SIZE-1:0] act_t;

   // Ties resolve to the first operand.
   function automatic act_t max_act(input act_t a, input act_t b);
      return (a >= b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row partial-max store for the 2x2 pooling stage: simple dual-port RAM,
// synchronous write, combinational read, no reset.
module pool_line_buffer #(
   parameter int DEPTH = 112,
   parameter int WIDTH = 8,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster-order feature map.
// Optional MAXPOOL_FUSED_RELU_EN clamps negative inputs to 0 before pooling.
module maxpool2x2_stream #(
   parameter int DATA_SIZE = 8,
   parameter int COLS      = 224,
   parameter int ROWS      = 224
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_SIZE-1:0] din,
   input  logic                 din_valid,
   output logic                 din_ready,
   output logic [DATA_SIZE-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic                 dout_last
);
   import vgg_pkg::*;

   localparam int COL_W = (COLS > 2) ? $clog2(COLS) : 1;
   localparam int ROW_W = (ROWS > 2) ? $clog2(ROWS) : 1;
   localparam int LB_DEPTH = COLS / 2;
   localparam int LB_AW = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   act_t             r_hold;
   act_t             r_dout;
   logic             r_dout_valid;
   logic             r_dout_last;

   act_t             w_din;
   act_t             w_lb_rd;
   act_t             w_pair_max;
   logic [LB_AW-1:0] w_lb_addr;
   logic             w_win_done;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_col_end;
   logic             w_row_end;
   logic             w_lb_wr;

`ifdef MAXPOOL_FUSED_RELU_EN
   assign w_din = din[DATA_SIZE-1] ? '0 : act_t'(din);
`else
   assign w_din = act_t'(din);
`endif

   assign w_win_done = r_row[0] & r_col[0];
   // Only the window-completing pixel needs the output register free.
   assign din_ready  = !w_win_done || !r_dout_valid || dout_ready;
   assign w_in_xfer  = din_valid & din_ready;
   assign w_out_xfer = r_dout_valid & dout_ready;
   assign w_col_end  = (r_col == COL_LAST);
   assign w_row_end  = (r_row == ROW_LAST);
   assign w_pair_max = max_act(r_hold, w_din);
   assign w_lb_addr  = LB_AW'(r_col >> 1);
   assign w_lb_wr    = w_in_xfer & ~r_row[0] & r_col[0];

   pool_line_buffer #(
      .DEPTH (LB_DEPTH),
      .WIDTH (DATA_SIZE),
      .AW    (LB_AW)
   ) u_line_buffer (
      .clk       (clk),
      .i_wr_en   (w_lb_wr),
      .i_wr_addr (w_lb_addr),
      .i_wr_data (w_pair_max),
      .i_rd_addr (w_lb_addr),
      .o_rd_data (w_lb_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col        <= '0;
         r_row        <= '0;
         r_hold       <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_dout_last  <= 1'b0;
      end else begin
         if (w_out_xfer) begin
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
         end
         if (w_in_xfer) begin
            if (w_col_end) begin
               r_col <= '0;
               r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            end else begin
               r_col <= r_col + COL_W'(1);
            end
            if (!r_col[0]) begin
               r_hold <= r_row[0] ? max_act(w_lb_rd, w_din) : w_din;
            end else if (r_row[0]) begin
               // A simultaneous output transfer is overridden here: reload.
               r_dout       <= w_pair_max;
               r_dout_valid <= 1'b1;
               r_dout_last  <= w_row_end & w_col_end;
            end
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign dout_last  = r_dout_last;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed self-checking bench for maxpool2x2_stream on a 4x4 feature map.
module tb_maxpool2x2_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready = 1'b1;
   logic       dout_last;

   int checks = 0;
   int errors = 0;

   logic [7:0] q_val[$];
   logic       q_last[$];

   logic [7:0] basic_frame[16] = '{8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd0, 8'd9, 8'd7,
                                   8'd8, 8'd8, 8'd1, 8'd1, 8'd2, 8'd6, 8'd3, 8'd10};
   logic [7:0] basic_exp[4] = '{8'd5, 8'd9, 8'd8, 8'd10};

   maxpool2x2_stream #(
      .DATA_SIZE (8),
      .COLS      (4),
      .ROWS      (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last)
   );

   always #5 clk = ~clk;

   // Inputs only change 1 time unit after a rising edge, so a transfer seen
   // here is the one that happens at the following rising edge.
   always @(negedge clk) begin
      if (rst_n && dout_valid && dout_ready) begin
         q_val.push_back(dout);
         q_last.push_back(dout_last);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] v);
      bit got;
      din = v;
      din_valid = 1'b1;
      @(negedge clk);
      got = din_ready;
      checks++;
      if (din_ready !== 1'b1) begin
         errors++;
         $display("FAIL din_ready_nonstall: got %b required 1 (pixel %0d)", din_ready, v);
      end
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         @(negedge clk);
         got = din_ready;
      end
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   task automatic do_reset();
      din_valid = 1'b0;
      dout_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      din = 8'h55;
      din_valid = 1'b1;
      dout_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b required 1", din_ready); end
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b required 0", dout_valid); end
      checks++;
      if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_dout_last: got %b required 0", dout_last); end
      checks++;
      if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h required 00", dout); end
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int idx;
      idx = 0;
      q_val.delete();
      q_last.delete();
      dout_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         send(basic_frame[k]);
         if (((k / 4) % 2 == 1) && (k % 2 == 1)) begin
            checks++;
            if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid[%0d]: got %b required 1", idx, dout_valid); end
            checks++;
            if (dout !== basic_exp[idx]) begin errors++; $display("FAIL basic_dout[%0d]: got %0d required %0d", idx, dout, basic_exp[idx]); end
            checks++;
            if (dout_last !== (idx == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %b required %b", idx, dout_last, idx == 3); end
            idx++;
         end
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: dout_valid got %b required 0", dout_valid); end
      checks++;
      if (q_val.size() != 4) begin errors++; $display("FAIL basic_count: got %0d outputs required 4", q_val.size()); end
      for (int i = 0; i < 4 && i < q_val.size(); i++) begin
         checks++;
         if (q_val[i] !== basic_exp[i] || q_last[i] !== (i == 3)) begin
            errors++;
            $display("FAIL basic_stream[%0d]: got %0d last %b required %0d last %b", i, q_val[i], q_last[i], basic_exp[i], i == 3);
         end
      end
   endtask

   task automatic test_backpressure();
      q_val.delete();
      q_last.delete();
      dout_ready = 1'b1;
      for (int k = 0; k < 6; k++) send(basic_frame[k]);
      dout_ready = 1'b0;
      send(basic_frame[6]);
      din = basic_frame[7];
      din_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b required 0", din_ready); end
         checks++;
         if (dout !== 8'd5 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got dout %0d valid %b required 5 valid 1", dout, dout_valid);
         end
      end
      @(posedge clk);
      #1;
      dout_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (din_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", din_ready); end
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      checks++;
      if (dout !== 8'd9 || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_reload: got dout %0d valid %b required 9 valid 1", dout, dout_valid);
      end
      for (int k = 8; k < 16; k++) send(basic_frame[k]);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (q_val.size() != 4) begin errors++; $display("FAIL bp_count: got %0d outputs required 4", q_val.size()); end
      for (int i = 0; i < 4 && i < q_val.size(); i++) begin
         checks++;
         if (q_val[i] !== basic_exp[i] || q_last[i] !== (i == 3)) begin
            errors++;
            $display("FAIL bp_stream[%0d]: got %0d last %b required %0d last %b", i, q_val[i], q_last[i], basic_exp[i], i == 3);
         end
      end
   endtask

   task automatic test_signed();
      logic [7:0] exp_v;
`ifdef MAXPOOL_FUSED_RELU_EN
      exp_v = 8'h00;
`else
      exp_v = 8'hFF;
`endif
      do_reset();
      send(8'hFD);
      send(8'hFF);
      send(8'h80);
      send(8'h80);
      send(8'hF8);
      send(8'hFE);
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_v) begin
         errors++;
         $display("FAIL signed_max: got %h valid %b required %h valid 1", dout, dout_valid, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      dout_ready = 1'b0;
      for (int k = 0; k < 6; k++) send(8'd77);
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'd77) begin
         errors++;
         $display("FAIL mid_pre: got %0d valid %b required 77 valid 1", dout, dout_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_async_clear: dout_valid got %b required 0", dout_valid); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_val.delete();
      q_last.delete();
      dout_ready = 1'b1;
      for (int k = 0; k < 16; k++) send(basic_frame[k]);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (q_val.size() != 4) begin errors++; $display("FAIL mid_count: got %0d outputs required 4", q_val.size()); end
      for (int i = 0; i < 4 && i < q_val.size(); i++) begin
         checks++;
         if (q_val[i] !== basic_exp[i] || q_last[i] !== (i == 3)) begin
            errors++;
            $display("FAIL mid_stream[%0d]: got %0d last %b required %0d last %b", i, q_val[i], q_last[i], basic_exp[i], i == 3);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pix[48];
      logic [7:0] exp_v[12];
      logic [7:0] m;
      logic [7:0] p;
      int         lasts;
      bit         got;
      do_reset();
      q_val.delete();
      q_last.delete();
      for (int n = 0; n < 48; n++) pix[n] = 8'($urandom);
      for (int f = 0; f < 3; f++) begin
         for (int w = 0; w < 4; w++) begin
            m = 8'h80;
            for (int r = 0; r < 2; r++) begin
               for (int c = 0; c < 2; c++) begin
                  p = pix[f * 16 + ((w / 2) * 2 + r) * 4 + (w % 2) * 2 + c];
`ifdef MAXPOOL_FUSED_RELU_EN
                  if (p[7]) p = 8'h00;
`endif
                  if ($signed(p) > $signed(m)) m = p;
               end
            end
            exp_v[f * 4 + w] = m;
         end
      end
      din_valid = 1'b1;
      for (int n = 0; n < 48; n++) begin
         din = pix[n];
         got = 1'b0;
         for (int i = 0; i < 50 && !got; i++) begin
            dout_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            got = din_ready;
            @(posedge clk);
            #1;
         end
         if (!got) begin
            checks++;
            errors++;
            $display("FAIL b2b_accept: pixel %0d not accepted within budget", n);
         end
      end
      din_valid = 1'b0;
      dout_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (q_val.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d outputs required 12", q_val.size()); end
      lasts = 0;
      for (int i = 0; i < 12 && i < q_val.size(); i++) begin
         if (q_last[i]) lasts++;
         checks++;
         if (q_val[i] !== exp_v[i] || q_last[i] !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL b2b_stream[%0d]: got %h last %b required %h last %b", i, q_val[i], q_last[i], exp_v[i], i % 4 == 3);
         end
      end
      checks++;
      if (lasts != 3) begin errors++; $display("FAIL b2b_last_count: got %0d required 3", lasts); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_signed();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of the ReLU stage in the VGG16 datapath. It accepts one DATA_SIZE-bit activation per handshake in row-major raster order and emits one pooled value per 2x2 window. A half-row line buffer holds the partial maxima, so a feature map is pooled in a single pass with no frame buffer.

## Interface
Parameters:
- DATA_SIZE, 8: activation width in bits, signed two's complement.
- COLS, 224: feature-map width in pixels; must be even and at least 2.
- ROWS, 224: feature-map height in pixels; must be even and at least 2.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- din, input, DATA_SIZE: input activation.
- din_valid, input, 1: din is valid.
- din_ready, output, 1: block accepts din this cycle.
- dout, output, DATA_SIZE: pooled activation.
- dout_valid, output, 1: dout is valid.
- dout_ready, input, 1: consumer accepts dout this cycle.
- dout_last, output, 1: qualifies dout as the final pooled value of a frame.

## Operation
- An input transfer occurs when din_valid and din_ready are both high. An output transfer occurs when dout_valid and dout_ready are both high.
- Counters:
  - col runs 0..COLS-1 and wraps to 0 at the end of each row.
  - row runs 0..ROWS-1 and wraps to 0 at the end of the frame, which also wraps the frame.
  - Both counters advance only on an input transfer.
- All comparisons are signed. max(a,b) returns a when a >= b.
- Even row, even col: hold <= din.
- Even row, odd col: linebuf[col>>1] <= max(hold, din).
- Odd row, even col: hold <= max(linebuf[col>>1], din).
- Odd row, odd col: the output register loads max(hold, din) and dout_valid is set.
- dout_last is set together with dout_valid when row==ROWS-1 and col==COLS-1.
- Backpressure rule: din_ready = !(row[0] && col[0]) || !dout_valid || dout_ready.
  - Only the window-completing input can stall.
  - All other inputs are always accepted.
- If dout_valid is held and dout_ready is low, dout and dout_last hold stable.
- If an output transfer and a window-completing input transfer happen in the same cycle, the register reloads: dout_valid stays 1 and dout takes the new value.
- On an output transfer with no reload, dout_valid clears to 0.
- Line buffer: COLS/2 entries, one write port and one read port.
  - The read is combinational or pre-fetched, so that linebuf[col>>1] is available on the odd-row, even-col transfer.
  - The read and write of the same address never coincide.

## Timing
- Reset values: din_ready=1, dout=0, dout_valid=0, dout_last=0, col=0, row=0, hold=0.
- Line buffer contents are not reset. Every entry is written before it is read.
- Latency: dout_valid rises on the clock edge after the window-completing input transfer, i.e. 1 cycle.
- Throughput: 1 input per cycle sustained with dout_ready tied high. The output rate is 1 per 4 inputs on average, bursting 1 per 2 cycles during odd rows.
- Asserting rst_n low mid-frame aborts the frame immediately:
  - counters and dout_valid clear asynchronously;
  - the next accepted pixel is treated as row 0, col 0.
- There is no combinational path from dout_ready to dout. The only combinational path is dout_ready to din_ready.

## Configuration
- MAXPOOL_FUSED_RELU_EN:
  - Defined: every accepted din with the MSB set is replaced by 0 before any compare or store. This gives a fused ReLU, so the separate ReLU stage can be bypassed.
  - Undefined: din is used unmodified and negative values propagate through the signed max.

## Structure
- The shared package vgg_pkg holds:
  - the DATA_SIZE constant;
  - the act_t typedef (signed DATA_SIZE);
  - a max_act function, which is also reused by later pooling layers.
- Sub-module pool_line_buffer is a simple dual-port RAM, COLS/2 x DATA_SIZE, one write port and one read port, with no reset. It infers as distributed or block RAM.
- The counters, hold register, output register and handshake logic stay in maxpool2x2_stream.

## Test plan
All tests use COLS=4, ROWS=4 unless stated.
- Reset check: assert rst_n low with din_valid high -> din_ready=1, dout_valid=0, dout_last=0 while reset is held.
- Basic pooling, dout_ready=1: input rows {1,5,2,3},{4,0,9,7},{8,8,1,1},{2,6,3,10} -> outputs 5,9,8,10. dout_last is high only with 10. Each output appears 1 cycle after its window-completing input.
- Backpressure: same frame with dout_ready=0 after the first output -> dout holds 5, and din_ready drops only at input index 7. Releasing dout_ready -> 9 follows with no loss or duplication.
- Signed compare, macro undefined: window {-3,-1,-8,-2} (0xFD,0xFF,0xF8,0xFE) -> output -1 (0xFF). With MAXPOOL_FUSED_RELU_EN defined -> output 0.
- Reset mid-frame: pulse rst_n low after 6 inputs, then send the full basic frame -> exactly outputs 5,9,8,10, with no stale partial output.
- Back-to-back frames, COLS=224, ROWS=224, random data, din_valid=1, random dout_ready -> 12544 outputs per frame match the reference model, and dout_last appears once per frame.
